// File: rtl/wb_accel_pkg.sv
// Shared constants and types for the Wishbone matrix-multiply engine.
package wb_accel_pkg;

    // Address space select, taken from address bits [31:30]
    localparam logic [1:0] SPACE_REG = 2'b00;
    localparam logic [1:0] SPACE_A   = 2'b01;
    localparam logic [1:0] SPACE_B   = 2'b10;
    localparam logic [1:0] SPACE_C   = 2'b11;

    // Register indices inside the register space (address bits [29:0])
    localparam logic [29:0] REG_CTRL   = 30'd0;
    localparam logic [29:0] REG_DIMS   = 30'd1;
    localparam logic [29:0] REG_STATUS = 30'd2;

    // STATUS bit positions
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MAC,
        ST_STORE,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/matmul_mac_core.sv
// Sequential signed multiply-accumulate with saturating or wrapping result.
module matmul_mac_core #(
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 2*DATA_W+3,
    parameter bit SATURATE = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] result_o
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    // Clamp the accumulator into the signed DATA_W range
    function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
        if (v > MAX_V)      return MAX_V[DATA_W-1:0];
        else if (v < MIN_V) return MIN_V[DATA_W-1:0];
        else                return v[DATA_W-1:0];
    endfunction

    // Keep only the low DATA_W bits of the accumulator
    function automatic logic signed [DATA_W-1:0] trunc_fn(input logic signed [ACC_W-1:0] v);
        return v[DATA_W-1:0];
    endfunction

    assign prod = a_i * b_i;

    // Next accumulator value: clear wins over accumulate
    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end

    // Accumulator is data only; every run clears it before use
    always_ff @(posedge clk_i) begin
        acc_q <= acc_d;
    end

    assign result_o = SATURATE ? sat_fn(acc_q) : trunc_fn(acc_q);

endmodule

// File: rtl/wb_matmul_engine.sv
// Wishbone-slave matrix multiply engine: C = A x B, one MAC per cycle.
module wb_matmul_engine
    import wb_accel_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_DIM  = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic              wishbone_clk_i,
    input  logic              wishbone_rst_i,
    input  logic [31:0]       wishbone_addr_i,
    input  logic              wishbone_we_i,
    input  logic [DATA_W-1:0] wishbone_data_i,
    input  logic              wishbone_stb,
    output logic              wishbone_ack,
    output logic [DATA_W-1:0] wishbone_data_o,
    output logic              done_irq_o
);

    localparam int IDX_W = $clog2(MAX_DIM);
    localparam int ACC_W = 2*DATA_W+IDX_W;

    state_e             state_q, state_d;
    logic               ack_q, irq_q;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [7:0]         m_q, k_q, n_q;
    logic               busy_q, done_q, err_q;
    logic [IDX_W-1:0]   i_q, j_q, kk_q;
    logic [DATA_W-1:0]  a_mem [MAX_DIM][MAX_DIM];
    logic [DATA_W-1:0]  b_mem [MAX_DIM][MAX_DIM];
    logic [DATA_W-1:0]  c_mem [MAX_DIM][MAX_DIM];
    logic [DATA_W-1:0]  mac_result;

    // Bus decode
    logic [1:0]       space;
    logic [IDX_W-1:0] row, col;
    logic [29:0]      reg_idx;
    logic             hi_zero, access, idle;
    logic             start, dims_wr, a_wr, b_wr;
    logic             dims_ok, k_last, j_last, i_last;

    assign space   = wishbone_addr_i[31:30];
    assign row     = wishbone_addr_i[2*IDX_W-1:IDX_W];
    assign col     = wishbone_addr_i[IDX_W-1:0];
    assign reg_idx = wishbone_addr_i[29:0];
    assign hi_zero = (wishbone_addr_i[29:2*IDX_W] == '0);
    assign access  = wishbone_stb && !ack_q;
    assign idle    = (state_q == ST_IDLE);

    // Writes that change state are only honoured while idle
    assign start   = access && wishbone_we_i && idle && (space == SPACE_REG)
                     && (reg_idx == REG_CTRL) && wishbone_data_i[0];
    assign dims_wr = access && wishbone_we_i && idle && (space == SPACE_REG) && (reg_idx == REG_DIMS);
    assign a_wr    = access && wishbone_we_i && idle && (space == SPACE_A) && hi_zero;
    assign b_wr    = access && wishbone_we_i && idle && (space == SPACE_B) && hi_zero;

    assign dims_ok = (m_q != 8'd0) && (k_q != 8'd0) && (n_q != 8'd0) &&
                     (m_q <= 8'(MAX_DIM)) && (k_q <= 8'(MAX_DIM)) && (n_q <= 8'(MAX_DIM));
    assign k_last  = (8'(kk_q) == k_q - 8'd1);
    assign j_last  = (8'(j_q)  == n_q - 8'd1);
    assign i_last  = (8'(i_q)  == m_q - 8'd1);

    matmul_mac_core #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_mac (
        .clk_i    (wishbone_clk_i),
        .clr_i    ((state_q == ST_CHECK) || (state_q == ST_STORE)),
        .en_i     (state_q == ST_MAC),
        .a_i      (a_mem[i_q][kk_q]),
        .b_i      (b_mem[kk_q][j_q]),
        .result_o (mac_result)
    );

    // Next-state logic for the run sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_CHECK;
            ST_CHECK:  state_d = dims_ok ? ST_MAC : ST_IDLE;
            ST_MAC:    if (k_last) state_d = ST_STORE;
            ST_STORE:  state_d = (i_last && j_last) ? ST_FINISH : ST_MAC;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Read mux; C is hidden while a run is in progress
    always_comb begin
        rdata_d = '0;
        case (space)
            SPACE_REG: begin
                if (reg_idx == REG_DIMS)
                    rdata_d = DATA_W'({8'd0, n_q, k_q, m_q});
                else if (reg_idx == REG_STATUS) begin
                    rdata_d[STATUS_BUSY_BIT] = busy_q;
                    rdata_d[STATUS_DONE_BIT] = done_q;
                    rdata_d[STATUS_ERR_BIT]  = err_q;
                end
            end
            SPACE_A: if (hi_zero) rdata_d = a_mem[row][col];
            SPACE_B: if (hi_zero) rdata_d = b_mem[row][col];
            SPACE_C: if (hi_zero && idle) rdata_d = c_mem[row][col];
            default: rdata_d = '0;
        endcase
    end

    // Control state, bus handshake, counters and status flags
    always_ff @(posedge wishbone_clk_i or posedge wishbone_rst_i) begin
        if (wishbone_rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            kk_q    <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= access;
            rdata_q <= access ? rdata_d : '0;
            irq_q   <= 1'b0;
            if (start) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (dims_wr) begin
                m_q <= wishbone_data_i[7:0];
                k_q <= wishbone_data_i[15:8];
                n_q <= wishbone_data_i[23:16];
            end
            case (state_q)
                ST_CHECK: begin
                    if (dims_ok) begin
                        busy_q <= 1'b1;
                        i_q    <= '0;
                        j_q    <= '0;
                        kk_q   <= '0;
                    end else begin
                        err_q  <= 1'b1;
                    end
                end
                ST_MAC:   kk_q <= kk_q + 1'b1;
                ST_STORE: begin
                    kk_q <= '0;
                    if (j_last) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                ST_FINISH: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    irq_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand storage; contents are undefined after reset
    always_ff @(posedge wishbone_clk_i) begin
        if (a_wr) a_mem[row][col] <= wishbone_data_i;
        if (b_wr) b_mem[row][col] <= wishbone_data_i;
    end

    // Result storage, cleared on reset and written once per element
    always_ff @(posedge wishbone_clk_i or posedge wishbone_rst_i) begin
        if (wishbone_rst_i) begin
            for (int r = 0; r < MAX_DIM; r++)
                for (int c = 0; c < MAX_DIM; c++)
                    c_mem[r][c] <= '0;
        end else if (state_q == ST_STORE) begin
            c_mem[i_q][j_q] <= mac_result;
        end
    end

    assign wishbone_ack    = ack_q;
    assign wishbone_data_o = rdata_q;
    assign done_irq_o      = irq_q;

endmodule
